// File: rtl/read_burst_pkg.sv
// Shared types for the read burst master: FSM state encoding and the
// return-buffer entry layout.
package read_burst_pkg;

    localparam int RB_DATA_WIDTH = 32;
    localparam int RB_ADDR_WIDTH = 11;
    localparam int RB_LEN_WIDTH  = 8;
    localparam int RB_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rb_state_e;

    typedef struct packed {
        logic [RB_DATA_WIDTH-1:0] data;
        logic                     last;
    } ret_entry_t;

    localparam int RET_ENTRY_WIDTH = $bits(ret_entry_t);

endpackage

// File: rtl/rb_fifo.sv
// Synchronous FIFO with a registered head word; count is exported so the
// producer can run credit-based flow control against it.
module rb_fifo #(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] head_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             do_pop;
    logic             do_push;
    logic             full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full        = (count_reg == CNT_W'(DEPTH));
    assign empty       = (count_reg == '0);
    assign do_pop      = pop && !empty;
    assign do_push     = push && (!full || do_pop);
    assign rd_ptr_next = do_pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Head is a registered read of the next entry; a word written into an
    // otherwise empty buffer is forwarded straight into the head register.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
                head_reg <= push_data;
            end else begin
                head_reg <= mem_reg[rd_ptr_next];
            end
        end
    end

    assign head_data = head_reg;
    assign count     = count_reg;

    overflow_check: assert property (@(posedge clk) disable iff (srst) !(push && full && !pop));

endmodule

// File: rtl/read_burst_master.sv
// Burst read engine: issues credit-limited single-word reads on a req/gnt/rvalid
// port and streams the returned words out with a last flag.
module read_burst_master
    import read_burst_pkg::*;
#(
    parameter int DATA_WIDTH = RB_DATA_WIDTH,
    parameter int ADDR_WIDTH = RB_ADDR_WIDTH,
    parameter int LEN_WIDTH  = RB_LEN_WIDTH,
    parameter int FIFO_DEPTH = RB_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  data_req_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    rb_state_e             state_reg;
    rb_state_e             state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH-1:0]  remaining_reg;
    logic                  inflight_reg;
    logic                  last_inflight_reg;
    logic                  zero_done_reg;
    logic                  drain_done;

    logic                  accept;
    logic                  grant;
    logic                  credit_ok;
    logic                  rvalid_push;
    logic                  pop;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    ret_entry_t            push_entry;
    ret_entry_t            head_entry;

    // Occupancy plus the word still in flight must leave room for one more.
    assign credit_ok   = ({1'b0, fifo_count} + (CNT_W + 1)'(inflight_reg)) < (CNT_W + 1)'(FIFO_DEPTH);
    // Ready is held low during a zero-length done pulse so done and accept never overlap.
    assign cmd_ready_o = (state_reg == IDLE) && !zero_done_reg;
    assign data_req_o  = (state_reg == ISSUE) && credit_ok;
    assign data_addr_o = addr_reg;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign grant       = data_req_o && data_gnt_i;
    assign rvalid_push = data_rvalid_i && (state_reg != IDLE);
    assign pop         = out_valid_o && out_ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy_o     = 1'b1;
        drain_done = 1'b0;
        case (state_reg)
            IDLE: begin
                busy_o = 1'b0;
                if (accept && (cmd_len_i != '0)) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (grant && (remaining_reg == LEN_WIDTH'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight_reg && fifo_empty) begin
                    state_next = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign done_o = drain_done || zero_done_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg          <= '0;
            remaining_reg     <= '0;
            inflight_reg      <= 1'b0;
            last_inflight_reg <= 1'b0;
            zero_done_reg     <= 1'b0;
        end else begin
            zero_done_reg <= accept && (cmd_len_i == '0);
            if (accept && (cmd_len_i != '0)) begin
                addr_reg      <= cmd_addr_i;
                remaining_reg <= cmd_len_i;
            end else if (grant) begin
                addr_reg      <= addr_reg + ADDR_WIDTH'(1);
                remaining_reg <= remaining_reg - LEN_WIDTH'(1);
            end
            // A grant in the same cycle as a return re-arms the flag for the new word.
            if (grant) begin
                inflight_reg      <= 1'b1;
                last_inflight_reg <= (remaining_reg == LEN_WIDTH'(1));
            end else if (rvalid_push) begin
                inflight_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.data = data_rdata_i;
        push_entry.last = last_inflight_reg;
    end

    rb_fifo #(
        .WIDTH (RET_ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (reset),
        .push      (rvalid_push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid_o = !fifo_empty;
    assign out_data_o  = head_entry.data;
    assign out_last_o  = !fifo_empty && head_entry.last;

endmodule

// File: tb/tb_read_burst_master.sv
// Directed bench for read_burst_master: the bench plays the interconnect slave
// and checks every cycle against a queue-based model of the expected traffic.
module tb_read_burst_master;

    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int LW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [AW-1:0] cmd_addr_i;
    logic [LW-1:0] cmd_len_i;
    logic          data_req_o;
    logic [AW-1:0] data_addr_o;
    logic          data_gnt_i;
    logic          data_rvalid_i;
    logic [DW-1:0] data_rdata_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          out_last_o;
    logic          busy_o;
    logic          done_o;

    always #5 clk = ~clk;

    read_burst_master dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_len_i     (cmd_len_i),
        .data_req_o    (data_req_o),
        .data_addr_o   (data_addr_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .out_last_o    (out_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // slave state
    bit            gnt_en       = 1'b1;
    bit            stray_rvalid = 1'b0;
    int            stall_at     = -1;
    int            stall_len    = 0;
    int            grant_count  = 0;
    int            wait_cnt     = 0;
    bit            hs           = 1'b0;
    logic [AW-1:0] hs_addr      = '0;

    // model state
    logic [AW-1:0] exp_addr_q [$];
    logic [DW:0]   exp_out_q  [$];
    bit            burst_active = 1'b0;
    int            done_due     = -1;
    int            outst        = 0;
    bit            prev_wait    = 1'b0;
    logic [AW-1:0] prev_addr    = '0;

    // per-test logs
    logic [AW-1:0] grant_log [$];
    logic [DW:0]   pop_log   [$];
    int            acc_cyc         = -1;
    int            first_req_cyc   = -1;
    int            first_valid_cyc = -1;
    int            last_pop_cyc    = -1;
    int            done_cyc        = -1;
    int            hold_cnt        = 0;
    logic [AW-1:0] watch_addr      = '0;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        grant_log.delete();
        pop_log.delete();
        first_req_cyc   = -1;
        first_valid_cyc = -1;
        last_pop_cyc    = -1;
        done_cyc        = -1;
        hold_cnt        = 0;
    endtask

    // Per-cycle compare against the model, called at the falling edge.
    task automatic sample();
        bit          exp_done;
        bit          exp_ready;
        logic [DW:0] head;
        exp_done  = (cyc == done_due);
        exp_ready = !burst_active && !exp_done;
        chk("done", 64'(done_o), 64'(exp_done));
        chk("busy", 64'(busy_o), 64'(burst_active));
        chk("cmd_ready", 64'(cmd_ready_o), 64'(exp_ready));
        if (prev_wait) begin
            chk("req_held", 64'(data_req_o), 64'(1));
            chk("addr_held", 64'(data_addr_o), 64'(prev_addr));
        end
        if (data_req_o && first_req_cyc < 0) first_req_cyc = cyc;
        if (data_req_o && data_addr_o == watch_addr) hold_cnt++;
        hs      = data_req_o && data_gnt_i;
        hs_addr = data_addr_o;
        if (hs) begin
            chk("req_expected", 64'(exp_addr_q.size() != 0), 64'(1));
            if (exp_addr_q.size() != 0) chk("req_addr", 64'(hs_addr), 64'(exp_addr_q.pop_front()));
            grant_log.push_back(hs_addr);
            outst++;
            grant_count++;
            wait_cnt = 0;
        end else if (data_req_o) begin
            wait_cnt++;
        end
        chk("credit", 64'(outst <= DEPTH), 64'(1));
        if (out_valid_o) begin
            chk("out_expected", 64'(exp_out_q.size() != 0), 64'(1));
            if (exp_out_q.size() != 0) begin
                head = exp_out_q[0];
                chk("out_data", 64'(out_data_o), 64'(head[DW:1]));
                chk("out_last", 64'(out_last_o), 64'(head[0]));
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_ready_i) begin
                    void'(exp_out_q.pop_front());
                    pop_log.push_back({out_data_o, out_last_o});
                    outst--;
                    if (head[0]) begin
                        done_due     = cyc + 1;
                        last_pop_cyc = cyc;
                    end
                end
            end
        end
        if (done_o) done_cyc = cyc;
        if (cmd_valid_i && exp_ready) begin
            acc_cyc = cyc;
            if (cmd_len_i == '0) begin
                done_due = cyc + 1;
            end else begin
                burst_active = 1'b1;
                for (int i = 0; i < int'(cmd_len_i); i++) begin
                    exp_addr_q.push_back(cmd_addr_i + AW'(i));
                    exp_out_q.push_back({word_of(cmd_addr_i + AW'(i)), i == int'(cmd_len_i) - 1});
                end
            end
        end
        if (exp_done) burst_active = 1'b0;
        prev_wait = data_req_o && !data_gnt_i && !reset;
        prev_addr = data_addr_o;
        if (reset) begin
            exp_addr_q.delete();
            exp_out_q.delete();
            burst_active = 1'b0;
            done_due     = -1;
            outst        = 0;
            prev_wait    = 1'b0;
        end
    endtask

    task automatic drive_slave();
        data_rvalid_i = hs || stray_rvalid;
        data_rdata_i  = hs ? word_of(hs_addr) : 32'hBAD0_BAD0;
        data_gnt_i    = gnt_en && !(grant_count == stall_at && wait_cnt < stall_len);
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive_slave();
        cyc++;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [LW-1:0] n);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = a;
        cmd_len_i   = n;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && done_cyc <= acc_cyc; i++) tick();
        chk(name, 64'(done_cyc > acc_cyc), 64'(1));
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, 64'(data_req_o), 64'(0));
        chk({tag, "_addr"}, 64'(data_addr_o), 64'(0));
        chk({tag, "_valid"}, 64'(out_valid_o), 64'(0));
        chk({tag, "_last"}, 64'(out_last_o), 64'(0));
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_done"}, 64'(done_o), 64'(0));
        chk({tag, "_ready"}, 64'(cmd_ready_o), 64'(1));
    endtask

    initial begin
        reset         = 1'b1;
        cmd_valid_i   = 1'b0;
        cmd_addr_i    = '0;
        cmd_len_i     = '0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        out_ready_i   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs("reset");

        // basic burst
        clear_logs();
        issue(11'h010, 8'd4);
        wait_done("basic_timeout", 40);
        chk("basic_grants", 64'(grant_log.size()), 64'(4));
        chk("basic_addr0", 64'(grant_log[0]), 64'(11'h010));
        chk("basic_addr3", 64'(grant_log[3]), 64'(11'h013));
        chk("basic_pops", 64'(pop_log.size()), 64'(4));
        chk("basic_word0", 64'(pop_log[0]), 64'({32'hC0DE_0010, 1'b0}));
        chk("basic_word3", 64'(pop_log[3]), 64'({32'hC0DE_0013, 1'b1}));
        chk("basic_req_lat", 64'(first_req_cyc - acc_cyc), 64'(1));
        chk("basic_out_lat", 64'(first_valid_cyc - acc_cyc), 64'(3));
        chk("basic_done_lat", 64'(done_cyc - last_pop_cyc), 64'(1));

        // grant stall on the second word
        clear_logs();
        watch_addr = 11'h011;
        stall_at   = grant_count + 1;
        stall_len  = 3;
        issue(11'h010, 8'd4);
        wait_done("stall_timeout", 40);
        stall_at = -1;
        chk("stall_hold", 64'(hold_cnt), 64'(4));
        chk("stall_grants", 64'(grant_log.size()), 64'(4));
        chk("stall_word3", 64'(pop_log[3]), 64'({32'hC0DE_0013, 1'b1}));

        // backpressure
        clear_logs();
        watch_addr  = 11'h7FF;
        out_ready_i = 1'b0;
        issue(11'h200, 8'd8);
        for (int i = 0; i < 10; i++) tick();
        chk("bp_grants_stalled", 64'(grant_log.size()), 64'(4));
        chk("bp_valid_stalled", 64'(out_valid_o), 64'(1));
        out_ready_i = 1'b1;
        wait_done("bp_timeout", 60);
        chk("bp_pops", 64'(pop_log.size()), 64'(8));
        chk("bp_word7", 64'(pop_log[7]), 64'({32'hC0DE_0207, 1'b1}));

        // address wrap
        clear_logs();
        issue(11'h7FE, 8'd3);
        wait_done("wrap_timeout", 40);
        chk("wrap_addr0", 64'(grant_log[0]), 64'(11'h7FE));
        chk("wrap_addr1", 64'(grant_log[1]), 64'(11'h7FF));
        chk("wrap_addr2", 64'(grant_log[2]), 64'(11'h000));
        chk("wrap_word2", 64'(pop_log[2]), 64'({32'hC0DE_0000, 1'b1}));

        // zero length
        clear_logs();
        issue(11'h123, 8'd0);
        wait_done("zero_timeout", 10);
        chk("zero_done_lat", 64'(done_cyc - acc_cyc), 64'(1));
        chk("zero_grants", 64'(grant_log.size()), 64'(0));

        // reset mid-burst
        clear_logs();
        issue(11'h100, 8'd6);
        for (int i = 0; i < 20 && grant_log.size() < 2; i++) tick();
        chk("rst_two_grants", 64'(grant_log.size() >= 2), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("midrst");
        stray_rvalid = 1'b1;
        tick();
        stray_rvalid = 1'b0;
        tick();
        chk("stray_ignored", 64'(out_valid_o), 64'(0));
        clear_logs();
        issue(11'h2A0, 8'd1);
        wait_done("after_rst_timeout", 20);
        chk("after_rst_pops", 64'(pop_log.size()), 64'(1));
        chk("after_rst_word", 64'(pop_log[0]), 64'({32'hC0DE_02A0, 1'b1}));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
